cls_value_printer: RTL and testbench

- Parametrised successor to the fixed 3-digit counter-to-LCD path: takes a WIDTH-bit unsigned value and converts it to DIGITS BCD digits with a sequential shift-add-3 converter.
- Formats the result as ASCII, with optional leading-zero blanking and overflow dashes.
- Streams a PmodCLS frame of cursor-position escape plus digit characters, byte-by-byte, to the existing spi_interface through its begin_transmission/end_transmission handshake.
- Replaces the number2bcd/bcd2ascii/command_lookup/master_interface chain for numeric fields; one instance per display field.

---
 rtl/cls_value_printer.sv | 187 ++++++++++++++++++
 tb/tb_cls_value_printer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cls_value_printer.sv
// cls_value_printer
//   Converts a WIDTH-bit unsigned value into DIGITS decimal characters with a
//   sequential double-dabble converter. The result is streamed to the PmodCLS
//   through spi_interface as one frame: a cursor-position escape "ESC [ row ; col H"
//   followed by the digits, most significant first. There is one instance per
//   numeric display field.
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   value[WIDTH-1:0]    number to display, captured when a frame is accepted
//   start               frame request, level-sensitive
//   end_transmission    spi_interface reports that the current byte has been shifted out
//   begin_transmission  one-cycle request to spi_interface; send_data is valid with it
//   send_data[7:0]      byte to transmit
//   slave_select        active-low, low for the whole frame
//   busy                high from accept until the frame ends
//   done                one-cycle pulse after the last byte completes
//   overflow            last accepted value did not fit in DIGITS digits
module cls_value_printer #(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 3,
   parameter int BLANK_ZEROS = 1,
   parameter int ROW         = 0,
   parameter int COL         = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] value,
   input  logic             start,
   input  logic             end_transmission,
   output logic             begin_transmission,
   output logic [7:0]       send_data,
   output logic             slave_select,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam int BW   = 4 * DIGITS;
   localparam int CW   = $clog2(WIDTH + 1);
   localparam int LAST = 5 + DIGITS;   // index of the final frame byte

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int j = 0; j < n; j++) r = r * 32'd10;
      return r;
   endfunction

   localparam logic [31:0] LIMIT = pow10(DIGITS);

   typedef enum logic [2:0] {
      S_IDLE, S_CONVERT, S_LOAD, S_SEND, S_WAIT, S_FINISH
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sh;        // value being shifted out MSB-first
   logic [BW-1:0]    bcd;
   logic [BW-1:0]    bcd_adj;
   logic [CW-1:0]    cnt;       // remaining conversion cycles minus one
   logic [3:0]       idx;       // frame byte index
   logic             pending;   // a start arrived while a frame was in flight
   logic             accept;
   logic [7:0]       byte_sel;

   // A pending request is served on the first IDLE cycle without needing start again.
   assign accept = (state == S_IDLE) && (start || pending);

   // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
   end

   // Byte for the current frame index. Position p counts digits from the most
   // significant one. The lead flag stays set while every digit seen so far is zero.
   always_comb begin
      logic       lead;
      logic [3:0] nib;
      logic [7:0] ch;
      lead     = 1'b1;
      nib      = 4'd0;
      ch       = 8'h00;
      byte_sel = 8'h00;
      case (idx)
         4'd0:    byte_sel = 8'h1B;
         4'd1:    byte_sel = 8'h5B;
         4'd2:    byte_sel = 8'h30 + 8'(ROW);
         4'd3:    byte_sel = 8'h3B;
         4'd4:    byte_sel = 8'h30 + 8'(COL);
         4'd5:    byte_sel = 8'h48;
         default: byte_sel = 8'h00;
      endcase
      for (int p = 0; p < DIGITS; p++) begin
         nib  = bcd[4*(DIGITS-1-p) +: 4];
         lead = lead && (nib == 4'd0);
         if (overflow)
            ch = 8'h2D;
         else if (BLANK_ZEROS != 0 && lead && p != DIGITS-1)
            ch = 8'h20;
         else
            ch = 8'h30 + {4'h0, nib};
         if (idx == 4'(6 + p)) byte_sel = ch;
      end
   end

   always_comb begin
      state_nx           = state;
      begin_transmission = 1'b0;
      slave_select       = 1'b1;
      busy               = 1'b0;
      done               = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nx = S_CONVERT;
         end
         S_CONVERT: begin
            busy = 1'b1;
            if (cnt == '0) state_nx = S_LOAD;
         end
         S_LOAD: begin
            busy         = 1'b1;
            slave_select = 1'b0;
            state_nx     = S_SEND;
         end
         S_SEND: begin
            busy               = 1'b1;
            slave_select       = 1'b0;
            begin_transmission = 1'b1;
            state_nx           = S_WAIT;
         end
         S_WAIT: begin
            busy         = 1'b1;
            slave_select = 1'b0;
            if (end_transmission) state_nx = (idx == 4'(LAST)) ? S_FINISH : S_LOAD;
         end
         S_FINISH: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sh        <= '0;
         bcd       <= '0;
         cnt       <= '0;
         idx       <= 4'd0;
         pending   <= 1'b0;
         overflow  <= 1'b0;
         send_data <= 8'h00;
      end else begin
         state <= state_nx;
         if (start && busy) pending <= 1'b1;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  pending  <= 1'b0;
                  sh       <= value;
                  bcd      <= '0;
                  cnt      <= CW'(WIDTH - 1);
                  idx      <= 4'd0;
                  overflow <= (32'(value) >= LIMIT);
               end
            end
            S_CONVERT: begin
               // Carries out of the top digit are dropped; overflow covers that case.
               bcd <= {bcd_adj[BW-2:0], sh[WIDTH-1]};
               sh  <= sh << 1;
               cnt <= cnt - 1'b1;
            end
            S_LOAD: send_data <= byte_sel;
            S_WAIT: begin
               if (end_transmission && idx != 4'(LAST)) idx <= idx + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cls_value_printer.sv
// Bench for cls_value_printer. It runs four configurations side by side:
//   0: WIDTH=8  DIGITS=3 blanking on,  row 0 col 0
//   1: WIDTH=8  DIGITS=3 blanking off, row 0 col 0
//   2: WIDTH=8  DIGITS=2 blanking on,  row 0 col 0
//   3: WIDTH=16 DIGITS=5 blanking on,  row 1 col 4
// Expected frame bytes go into a scoreboard queue when a start is driven. Each
// entry is tagged with its instance, and the monitor pops the queue on every
// begin_transmission.
module tb_cls_value_printer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spur = 1'b0;
   logic       st [4];
   logic       et [4];
   logic       bt [4];
   logic       ss [4];
   logic       bsy [4];
   logic       dn [4];
   logic       ov [4];
   logic [7:0] sd [4];
   logic [7:0] v8 [3];
   logic [15:0] v16;

   always #5 clk = ~clk;

   cls_value_printer #(.WIDTH(8), .DIGITS(3), .BLANK_ZEROS(1), .ROW(0), .COL(0)) u0 (
      .clk(clk), .rst_n(rst_n), .value(v8[0]), .start(st[0]), .end_transmission(et[0] | spur),
      .begin_transmission(bt[0]), .send_data(sd[0]), .slave_select(ss[0]), .busy(bsy[0]),
      .done(dn[0]), .overflow(ov[0]));
   cls_value_printer #(.WIDTH(8), .DIGITS(3), .BLANK_ZEROS(0), .ROW(0), .COL(0)) u1 (
      .clk(clk), .rst_n(rst_n), .value(v8[1]), .start(st[1]), .end_transmission(et[1]),
      .begin_transmission(bt[1]), .send_data(sd[1]), .slave_select(ss[1]), .busy(bsy[1]),
      .done(dn[1]), .overflow(ov[1]));
   cls_value_printer #(.WIDTH(8), .DIGITS(2), .BLANK_ZEROS(1), .ROW(0), .COL(0)) u2 (
      .clk(clk), .rst_n(rst_n), .value(v8[2]), .start(st[2]), .end_transmission(et[2]),
      .begin_transmission(bt[2]), .send_data(sd[2]), .slave_select(ss[2]), .busy(bsy[2]),
      .done(dn[2]), .overflow(ov[2]));
   cls_value_printer #(.WIDTH(16), .DIGITS(5), .BLANK_ZEROS(1), .ROW(1), .COL(4)) u3 (
      .clk(clk), .rst_n(rst_n), .value(v16), .start(st[3]), .end_transmission(et[3]),
      .begin_transmission(bt[3]), .send_data(sd[3]), .slave_select(ss[3]), .busy(bsy[3]),
      .done(dn[3]), .overflow(ov[3]));

   typedef struct {
      int          k;
      int          val;
      int          nd;
      logic [39:0] dig;   // expected digit bytes, right-aligned, MSB digit first
      logic        ovf;
   } vec_t;

   vec_t       tbl [$];
   logic [9:0] exp_q [$];   // {instance, byte}
   int         n_vec = 0;
   int         n_err = 0;
   int         nbytes [4];
   int         ndone [4];
   int         rcnt [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard side of the monitor: check every byte when it is requested.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bt[k]) begin
            nbytes[k]++;
            chk("ss_low_at_byte", 32'(ss[k]), 32'd0);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: inst %0d got %h required none", k, sd[k]);
            end else begin
               chk("frame_byte", {22'd0, 2'(k), sd[k]}, 32'(exp_q.pop_front()));
            end
         end
         if (dn[k]) ndone[k]++;
      end
   end

   // spi_interface model: end_transmission rises 3 cycles after a request and
   // stays high for 2 cycles. The second cycle falls outside WAIT.
   initial begin
      for (int k = 0; k < 4; k++) begin et[k] = 1'b0; rcnt[k] = 0; end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
               rcnt[k] = 0; et[k] = 1'b0;
            end else if (bt[k]) begin
               rcnt[k] = 4; et[k] = 1'b0;
            end else if (rcnt[k] > 0) begin
               rcnt[k]--; et[k] = (rcnt[k] <= 1);
            end else begin
               et[k] = 1'b0;
            end
         end
      end
   end

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input int k, input int val, input logic s);
      if (k == 3) v16 = 16'(val);
      else v8[k] = 8'(val);
      st[k] = s;
   endtask

   task automatic push_frame(input int k, input int nd, input logic [39:0] dig);
      logic [1:0] t;
      t = 2'(k);
      exp_q.push_back({t, 8'h1B});
      exp_q.push_back({t, 8'h5B});
      exp_q.push_back({t, (k == 3) ? 8'h31 : 8'h30});
      exp_q.push_back({t, 8'h3B});
      exp_q.push_back({t, (k == 3) ? 8'h34 : 8'h30});
      exp_q.push_back({t, 8'h48});
      for (int p = 0; p < nd; p++) exp_q.push_back({t, dig[8*(nd-1-p) +: 8]});
   endtask

   task automatic wait_done(input int k, input int target);
      int n;
      n = 0;
      while (ndone[k] < target && n < 400) begin step; n++; end
      chk("done_count", 32'(ndone[k]), 32'(target));
   endtask

   task automatic frame(input int k, input int val, input int nd, input logic [39:0] dig,
                        input logic ovf);
      int n, b0, d0;
      b0 = nbytes[k];
      d0 = ndone[k];
      push_frame(k, nd, dig);
      drive(k, val, 1'b1);
      step;
      st[k] = 1'b0;
      n = 1;
      while (!bt[k] && n < 60) begin step; n++; end
      chk("first_byte_latency", 32'(n), (k == 3) ? 32'd18 : 32'd10);
      wait_done(k, d0 + 1);
      chk("overflow", 32'(ov[k]), 32'(ovf));
      chk("busy_at_done", 32'(bsy[k]), 32'd0);
      chk("ss_at_done", 32'(ss[k]), 32'd1);
      step;
      chk("byte_count", 32'(nbytes[k] - b0), 32'(6 + nd));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("done_once", 32'(ndone[k] - d0), 32'd1);
   endtask

   initial begin
      int b0, d0, n;
      for (int k = 0; k < 4; k++) begin st[k] = 1'b0; nbytes[k] = 0; ndone[k] = 0; end
      for (int k = 0; k < 3; k++) v8[k] = 8'd0;
      v16 = 16'd0;

      tbl.push_back('{0, 123,   3, 40'h313233,     1'b0});
      tbl.push_back('{0, 7,     3, 40'h202037,     1'b0});
      tbl.push_back('{0, 0,     3, 40'h202030,     1'b0});
      tbl.push_back('{0, 10,    3, 40'h203130,     1'b0});
      tbl.push_back('{0, 255,   3, 40'h323535,     1'b0});
      tbl.push_back('{1, 7,     3, 40'h303037,     1'b0});
      tbl.push_back('{1, 0,     3, 40'h303030,     1'b0});
      tbl.push_back('{2, 200,   2, 40'h2D2D,       1'b1});
      tbl.push_back('{2, 99,    2, 40'h3939,       1'b0});
      tbl.push_back('{2, 100,   2, 40'h2D2D,       1'b1});
      tbl.push_back('{2, 5,     2, 40'h2035,       1'b0});
      tbl.push_back('{3, 65535, 5, 40'h3635353335, 1'b0});
      tbl.push_back('{3, 100,   5, 40'h2020313030, 1'b0});
      tbl.push_back('{3, 0,     5, 40'h2020202030, 1'b0});

      // Reset state
      step;
      step;
      for (int k = 0; k < 4; k++) begin
         chk("rst_ss", 32'(ss[k]), 32'd1);
         chk("rst_bt", 32'(bt[k]), 32'd0);
         chk("rst_sd", 32'(sd[k]), 32'd0);
         chk("rst_busy", 32'(bsy[k]), 32'd0);
         chk("rst_done", 32'(dn[k]), 32'd0);
         chk("rst_ovf", 32'(ov[k]), 32'd0);
      end
      rst_n = 1'b1;
      step;

      foreach (tbl[i]) frame(tbl[i].k, tbl[i].val, tbl[i].nd, tbl[i].dig, tbl[i].ovf);

      // A spurious end_transmission during conversion must not disturb the frame.
      d0 = ndone[0];
      push_frame(0, 3, 40'h313233);
      drive(0, 123, 1'b1);
      step;
      st[0] = 1'b0;
      spur = 1'b1;
      repeat (3) step;
      spur = 1'b0;
      wait_done(0, d0 + 1);
      step;
      chk("spur_queue_empty", 32'(exp_q.size()), 32'd0);

      // Three re-pulses of start mid-frame yield exactly one extra frame with value 42.
      d0 = ndone[0];
      push_frame(0, 3, 40'h313233);
      push_frame(0, 3, 40'h203432);
      drive(0, 123, 1'b1);
      step;
      st[0] = 1'b0;
      repeat (15) step;
      drive(0, 42, 1'b1);
      step;
      st[0] = 1'b0;
      repeat (10) step;
      st[0] = 1'b1;
      step;
      st[0] = 1'b0;
      repeat (5) step;
      st[0] = 1'b1;
      step;
      st[0] = 1'b0;
      wait_done(0, d0 + 1);
      step;
      chk("gap_busy_low", 32'(bsy[0]), 32'd0);
      chk("gap_ss_high", 32'(ss[0]), 32'd1);
      step;
      chk("reaccept_busy", 32'(bsy[0]), 32'd1);
      wait_done(0, d0 + 2);
      b0 = nbytes[0];
      repeat (40) step;
      chk("no_third_frame", 32'(ndone[0] - d0), 32'd2);
      chk("no_extra_bytes", 32'(nbytes[0] - b0), 32'd0);
      chk("repulse_queue_empty", 32'(exp_q.size()), 32'd0);

      // start held high gives back-to-back frames with one IDLE cycle between them.
      d0 = ndone[2];
      push_frame(2, 2, 40'h3939);
      push_frame(2, 2, 40'h3939);
      drive(2, 99, 1'b1);
      wait_done(2, d0 + 1);
      step;
      chk("held_gap_busy", 32'(bsy[2]), 32'd0);
      chk("held_gap_ss", 32'(ss[2]), 32'd1);
      step;
      chk("held_reaccept", 32'(bsy[2]), 32'd1);
      st[2] = 1'b0;
      wait_done(2, d0 + 2);
      repeat (30) step;
      chk("held_two_frames", 32'(ndone[2] - d0), 32'd2);
      chk("held_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset while byte 4 is in flight aborts the frame immediately.
      b0 = nbytes[0];
      push_frame(0, 3, 40'h313233);
      drive(0, 123, 1'b1);
      step;
      st[0] = 1'b0;
      n = 0;
      while (nbytes[0] < b0 + 5 && n < 200) begin step; n++; end
      chk("reached_byte4", 32'(nbytes[0] - b0), 32'd5);
      rst_n = 1'b0;
      #1;
      chk("abort_ss", 32'(ss[0]), 32'd1);
      chk("abort_busy", 32'(bsy[0]), 32'd0);
      chk("abort_bt", 32'(bt[0]), 32'd0);
      chk("abort_sd", 32'(sd[0]), 32'd0);
      exp_q.delete();
      step;
      step;
      rst_n = 1'b1;
      b0 = nbytes[0];
      repeat (40) step;
      chk("no_bytes_after_abort", 32'(nbytes[0] - b0), 32'd0);
      chk("idle_after_abort", 32'(bsy[0]), 32'd0);
      frame(0, 7, 3, 40'h202037, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end
endmodule
